// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall sequencer for the 5-stage pipeline: load-use bubbles, ID operand forwarding,
// branch flush, data-memory wait freeze with watchdog, and saturating stall counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_branch,
    input  logic [4:0]       exe_rn,
    input  logic             exe_wreg,
    input  logic             exe_m2reg,
    input  logic [4:0]       mem_rn,
    input  logic             mem_wreg,
    input  logic             mem_m2reg,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             lock_write,
    output logic             id_exe_hold,
    output logic             if_flush,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic             wd_err,
    output logic [CNT_W-1:0] ldstall_cnt,
    output logic [CNT_W-1:0] memwait_cnt
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        ERR     = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
    logic                load_use;
    logic                memwait;
    logic                freeze;
    logic                run_dec;
    logic                ld_inc;
    logic                mw_inc;

    // EXE ALU result wins over MEM; EXE loads are not yet available and stall instead.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] e_rn,
        input logic       e_wreg,
        input logic       e_m2reg,
        input logic [4:0] m_rn,
        input logic       m_wreg,
        input logic       m_m2reg
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (src != 5'd0) begin
            if (e_wreg && !e_m2reg && (e_rn == src)) begin
                sel = 2'd1;
            end else if (m_wreg && (m_rn == src)) begin
                sel = m_m2reg ? 2'd3 : 2'd2;
            end
        end
        return sel;
    endfunction

    always_comb begin
        fwda = fwd_sel(id_rs, exe_rn, exe_wreg, exe_m2reg, mem_rn, mem_wreg, mem_m2reg);
        fwdb = fwd_sel(id_rt, exe_rn, exe_wreg, exe_m2reg, mem_rn, mem_wreg, mem_m2reg);
    end

    assign load_use = exe_wreg && exe_m2reg && (exe_rn != 5'd0) &&
                      ((id_use_rs && (exe_rn == id_rs)) || (id_use_rt && (exe_rn == id_rt)));
    assign memwait  = mem_req && !mem_ready;

    // Next-state and stage-control decode.
    always_comb begin
        state_nxt   = state;
        wait_nxt    = wait_cnt;
        freeze      = 1'b0;
        run_dec     = 1'b0;
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        lock_write  = 1'b0;
        id_exe_hold = 1'b0;
        if_flush    = 1'b0;

        case (state)
            RUN: begin
                if (memwait) begin
                    freeze    = 1'b1;
                    state_nxt = MEMWAIT;
                    wait_nxt  = WAIT_W'(1);
                end else begin
                    run_dec = 1'b1;
                end
            end
            MEMWAIT: begin
                if (memwait) begin
                    freeze = 1'b1;
                    if (wait_cnt == WAIT_W'(MAX_WAIT)) begin
                        state_nxt = ERR;
                    end else begin
                        wait_nxt = wait_cnt + WAIT_W'(1);
                    end
                end else begin
                    run_dec   = 1'b1;
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end
            end
            ERR: begin
                freeze = 1'b1;
            end
            default: begin
                state_nxt = RUN;
                wait_nxt  = '0;
            end
        endcase

        if (freeze) begin
            id_exe_hold = 1'b1;
        end else if (run_dec) begin
            if (load_use) begin
                lock_write = 1'b1;
            end else begin
                pc_we    = 1'b1;
                if_id_we = 1'b1;
                if_flush = id_branch;
            end
        end
    end

    assign ld_inc = run_dec && load_use;
    assign mw_inc = memwait && (state != ERR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            wd_err      <= 1'b0;
            ldstall_cnt <= '0;
            memwait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (state_nxt == ERR) begin
                wd_err <= 1'b1;
            end
            if (ld_inc && (ldstall_cnt != {CNT_W{1'b1}})) begin
                ldstall_cnt <= ldstall_cnt + CNT_W'(1);
            end
            if (mw_inc && (memwait_cnt != {CNT_W{1'b1}})) begin
                memwait_cnt <= memwait_cnt + CNT_W'(1);
            end
        end
    end

endmodule
